// File: rtl/param_accum_counter.sv
// ---------------------------------------------------------------------------
// param_accum_counter
//
// Up/down accumulating counter with a programmable range [0, limit].
// Each enabled clock edge adds or subtracts an unsigned step. When a step
// would leave the range, a boundary event happens. In the default build
// the counter wraps to the opposite end of the range and pulses 'wrap' for
// one cycle. With PARAM_ACCUM_SAT_EN defined it clamps at the end it hit and
// raises a sticky 'sat' flag instead.
//
// Configuration macro:
//   PARAM_ACCUM_SAT_EN - saturate at the boundary instead of wrapping.
//
// Parameters:
//   WIDTH  - counter and limit width in bits (4..64)
//   STEP_W - step input width in bits (must not exceed WIDTH)
//
// Ports:
//   clk        in   clock; all state changes on its rising edge
//   reset      in   asynchronous, active-high reset
//   en         in   count enable
//   up         in   direction: 1 = add step, 0 = subtract step
//   step       in   unsigned step amount
//   limit      in   unsigned upper bound of the count range
//   load       in   synchronous load strobe (takes priority over en)
//   load_value in   value written to count on load
//   count      out  registered counter value
//   wrap       out  registered one-cycle boundary pulse (wrap build only)
//   tc         out  combinational terminal count, high when count == limit
//   sat        out  registered sticky saturation flag (saturating build only)
// ---------------------------------------------------------------------------
module param_accum_counter #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              tc,
  output logic              sat
);

  // One extra bit of headroom so that count + step can never overflow
  // before it is compared against limit.
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   limit_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic             step_zero;
  logic             up_fits;
  logic             down_fits;

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign count_ext = {1'b0, count};
  assign limit_ext = {1'b0, limit};
  assign step_ext  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum_ext   = count_ext + step_ext;
  assign diff      = count - step_ext[WIDTH-1:0];
  assign step_zero = (step == '0);
  assign up_fits   = (sum_ext <= limit_ext);
  assign down_fits = (count_ext >= step_ext);

  // Terminal count tracks count and limit with no register in the path.
  assign tc = (count == limit);

`ifdef PARAM_ACCUM_SAT_EN

  logic sat_next;

  // Next-state selection, saturating flavour. A zero step is a true no-op:
  // without that guard an out-of-range count (count > limit after a load)
  // would look like an up-boundary even though nothing moved.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    sat_next   = sat;
    if (load) begin
      count_next = load_value;
      sat_next   = 1'b0;
    end else if (en && !step_zero) begin
      if (up) begin
        if (up_fits) begin
          count_next = sum_ext[WIDTH-1:0];
        end else begin
          count_next = limit;
          sat_next   = 1'b1;
        end
      end else begin
        if (down_fits) begin
          count_next = diff;
        end else begin
          count_next = '0;
          sat_next   = 1'b1;
        end
      end
    end
  end

  // Sticky saturation flag; only load or reset clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat <= 1'b0;
    end else begin
      sat <= sat_next;
    end
  end

`else

  // Next-state selection, wrapping flavour. Crossing the top of the range
  // lands on 0, crossing the bottom lands on limit, and wrap is raised for
  // the following cycle. A zero step never moves the count or wraps.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (en && !step_zero) begin
      if (up) begin
        if (up_fits) begin
          count_next = sum_ext[WIDTH-1:0];
        end else begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        if (down_fits) begin
          count_next = diff;
        end else begin
          count_next = limit;
          wrap_next  = 1'b1;
        end
      end
    end
  end

  assign sat = 1'b0;

`endif

  // Count and wrap registers. wrap_next defaults low every cycle, so the
  // pulse lasts exactly one cycle unless the next edge is also a boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule

// File: doc/param_accum_counter.md
PARAM_ACCUM_COUNTER -- requirements
Module: param_accum_counter

Interface
REQ-001 Parameter WIDTH, default 32: counter and limit width in bits; legal range 4..64.
REQ-002 Parameter STEP_W, default 4: step input width in bits; SHALL satisfy STEP_W <= WIDTH.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: reset is asynchronous and active-high.
REQ-005 Port en  input  1: count enable; when low and load low, count holds.
REQ-006 Port up  input  1: direction select; 1 = add step, 0 = subtract step.
REQ-007 Port step  input  STEP_W: unsigned increment/decrement amount, sampled each enabled edge.
REQ-008 Port limit  input  WIDTH: unsigned upper bound of count range [0, limit].
REQ-009 Port load  input  1: synchronous load strobe.
REQ-010 Port load_value  input  WIDTH: value written to count on load.
REQ-011 Port count  output  WIDTH: registered counter value.
REQ-012 Port wrap  output  1: registered one-cycle pulse indicating a range boundary was crossed.
REQ-013 Port tc  output  1: combinational terminal-count flag, high when count == limit.
REQ-014 Port sat  output  1: registered sticky saturation flag (see Configuration).

Function
REQ-015 Priority per edge SHALL be: reset > load > en > hold.
REQ-016 Load SHALL set count = load_value (even if > limit), clear wrap, clear sat.
REQ-017 Arithmetic SHALL use WIDTH+1 bits with step zero-extended; no truncation before comparison.
REQ-018 Up, en: if count + step <= limit then count += step, else boundary event (REQ-020).
REQ-019 Down, en: if count >= step then count -= step, else boundary event (REQ-020).
REQ-020 Boundary event, wrap build: up -> count = 0; down -> count = limit; wrap = 1 on the following cycle.
REQ-021 wrap SHALL be high exactly one cycle after each boundary edge and low otherwise, including across back-to-back boundary events (high each cycle).
REQ-022 step = 0 with en SHALL leave count unchanged and raise no wrap, even when count > limit.
REQ-023 count > limit (after load or limit change) with up and step > 0 SHALL trigger a boundary event.
REQ-024 tc SHALL follow count and limit combinationally with zero latency.
REQ-025 Latency from en/step sample to updated count SHALL be one clock.

Reset
REQ-026 Asserting reset SHALL immediately force count = 0, wrap = 0, sat = 0 regardless of clk.
REQ-027 Reset asserted mid-count SHALL discard any pending boundary event; first edge after release SHALL behave as from count = 0.

Configuration
REQ-028 Macro PARAM_ACCUM_SAT_EN SHALL select saturation instead of wrapping.
REQ-029 With PARAM_ACCUM_SAT_EN defined: up boundary -> count = limit; down boundary -> count = 0; wrap stays 0; sat set to 1 and held until load or reset.
REQ-030 Without PARAM_ACCUM_SAT_EN: REQ-020 wrap behaviour applies and sat SHALL be tied to 0.

Verification (WIDTH=32, STEP_W=4 unless stated)
REQ-031 Reset, then en=1 up=1 step=3 limit=100 for 4 edges -> count 3,6,9,12; wrap=0; tc=0.
REQ-032 load_value=98, limit=100, step=5 up -> next edge count=0 (wrap build), wrap=1 for exactly one cycle; sat build: count=100, tc=1, sat=1 sticky.
REQ-033 count=2, up=0, step=5, limit=50 -> wrap build count=50, wrap pulse, tc=1; sat build count=0, sat=1; subsequent load clears sat.
REQ-034 load and en both high with load_value=7 -> count=7, no arithmetic applied that edge; en=0 for 3 edges -> count stays 7.
REQ-035 Reset asserted between edges while count=40 -> count=0 immediately, wrap=0; release, step=2 up -> count 2,4 on next edges.
REQ-036 WIDTH=8, limit=255, count=254, step=1 up -> count=255, tc=1; next edge (wrap build) count=0 with wrap pulse, no X from 9-bit sum.
